// File: rtl/mod_add_initiator_pkg.sv
`default_nettype none
// ============================================================================
// mod_add_initiator_pkg -- shared widths, timeout default and FSM encoding
// Revision: 1.0
// ============================================================================
package mod_add_initiator_pkg;

  localparam int DEFAULT_WIDTH   = 513;
  localparam int DEFAULT_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADD    = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mod_add_initiator_wait_counter.sv
`default_nettype none
// ============================================================================
// mod_add_initiator_wait_counter -- cycle counter bounding the engine wait
// Revision: 1.0
// ============================================================================
module mod_add_initiator_wait_counter #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic resetn,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mod_add_initiator.sv
`default_nettype none
// ============================================================================
// mod_add_initiator -- (a+b) mod n: wide add, then hand-off to reduction engine
// Revision: 1.0
// ============================================================================
module mod_add_initiator
  import mod_add_initiator_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] res,
  output logic             mod_start,
  output logic [WIDTH-1:0] mod_a,
  output logic [WIDTH-1:0] mod_n,
  input  logic [WIDTH-1:0] mod_res,
  input  logic             mod_done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] mod_a_q, mod_a_d;
  logic [WIDTH-1:0] mod_n_q, mod_n_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;
  logic [WIDTH:0]   sum;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_last;

  // Single wide add; its registered form is the engine operand mod_a_q.
  assign sum = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ADD;
      ST_ADD:    state_d = sum[WIDTH] ? ST_FINISH : ST_ISSUE;
      ST_ISSUE:  state_d = ST_WAIT;
      ST_WAIT:   if (mod_done || cnt_last) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_FINISH);
    err       = (state_q == ST_FINISH) && (ovf_q || tmo_q);
    mod_start = (state_q == ST_ISSUE);
    cnt_clr   = (state_q == ST_ISSUE);
    cnt_inc   = (state_q == ST_WAIT);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    res_d   = res_q;
    mod_a_d = mod_a_q;
    mod_n_d = mod_n_q;
    ovf_d   = ovf_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          n_d   = n;
          ovf_d = 1'b0;
          tmo_d = 1'b0;
        end
      end
      ST_ADD: begin
        if (sum[WIDTH]) begin
          ovf_d = 1'b1;
        end else begin
          mod_a_d = sum[WIDTH-1:0];
          mod_n_d = n_q;
        end
      end
      ST_WAIT: begin
        // A response on the terminal-count cycle still counts as success.
        if (mod_done) begin
          res_d = mod_res;
        end else if (cnt_last) begin
          tmo_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      res_q   <= '0;
      mod_a_q <= '0;
      mod_n_q <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      n_q     <= n_d;
      res_q   <= res_d;
      mod_a_q <= mod_a_d;
      mod_n_q <= mod_n_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign res   = res_q;
  assign mod_a = mod_a_q;
  assign mod_n = mod_n_q;

  mod_add_initiator_wait_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_counter (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .last   (cnt_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_mod_add_initiator.sv
`default_nettype none
// ============================================================================
// tb_mod_add_initiator -- directed vectors with a latency-programmable engine
// Revision: 1.0
// ============================================================================
module tb_mod_add_initiator;

  localparam int W     = 513;
  localparam int TO    = 20;
  localparam int LIMIT = 60;

  logic         clk      = 1'b0;
  logic         resetn   = 1'b0;
  logic         start    = 1'b0;
  logic [W-1:0] a        = '0;
  logic [W-1:0] b        = '0;
  logic [W-1:0] n        = '0;
  logic         busy, done, err, mod_start;
  logic [W-1:0] res, mod_a, mod_n;
  logic [W-1:0] mod_res  = '0;
  logic         mod_done = 1'b0;

  int total = 0;
  int bad   = 0;

  int           ms_cnt   = 0;
  int           done_cnt = 0;
  logic [W-1:0] ms_a     = '0;
  logic [W-1:0] ms_n     = '0;
  int           eng_lat  = 1;
  int           eng_rem  = 0;
  bit           eng_en   = 1'b1;
  bit           eng_go   = 1'b0;
  logic [W-1:0] eng_val  = '0;

  always #5 clk = ~clk;

  mod_add_initiator #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .a         (a),
    .b         (b),
    .n         (n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .res       (res),
    .mod_start (mod_start),
    .mod_a     (mod_a),
    .mod_n     (mod_n),
    .mod_res   (mod_res),
    .mod_done  (mod_done)
  );

  // Observe requests mid-cycle; the engine answers eng_lat cycles after mod_start.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mod_start) begin
      ms_cnt++;
      ms_a = mod_a;
      ms_n = mod_n;
      if (eng_en) begin
        eng_val = mod_a % mod_n;
        eng_go  = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    mod_done <= 1'b0;
    if (eng_go) begin
      eng_go  = 1'b0;
      eng_rem = eng_lat;
    end
    if (eng_rem > 0) begin
      eng_rem--;
      if (eng_rem == 0) begin
        mod_done <= 1'b1;
        mod_res  <= eng_val;
      end
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Start cycle is cycle 1; lat is the cycle index in which done is seen (0 = never).
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic [W-1:0] tn,
                        input int lat_e, input int hold,
                        output int lat, output logic e, output logic [W-1:0] r);
    eng_lat = lat_e;
    lat     = 0;
    e       = 1'b0;
    r       = '0;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    n     = tn;
    @(posedge clk); #1;
    for (int i = 2; i < LIMIT; i++) begin
      start = (i <= hold);
      if (done && lat == 0) begin
        lat = i;
        e   = err;
        r   = res;
      end
      if (lat != 0 && i > hold) break;
      @(posedge clk); #1;
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int           lat;
    int           ms0;
    int           dn0;
    logic         e;
    logic [W-1:0] r;
    logic [W-1:0] big;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  W'(busy),      '0);
    chk("rst_done",  W'(done),      '0);
    chk("rst_err",   W'(err),       '0);
    chk("rst_res",   res,           '0);
    chk("rst_mstart", W'(mod_start), '0);
    chk("rst_mod_a", mod_a,         '0);
    chk("rst_mod_n", mod_n,         '0);
    @(negedge clk);
    resetn = 1'b1;

    // 5 + 9 = 14, engine latency 3
    ms0 = ms_cnt;
    do_txn(W'(5), W'(9), W'(11), 3, 1, lat, e, r);
    chk("t1_lat",   W'(lat),          W'(7));
    chk("t1_nreq",  W'(ms_cnt - ms0), W'(1));
    chk("t1_mod_a", ms_a,             W'(14));
    chk("t1_mod_n", ms_n,             W'(11));
    chk("t1_res",   r,                W'(3));
    chk("t1_err",   W'(e),            '0);
    chk("t1_idle",  W'(busy),         '0);

    // 2^512 + 2^512 carries out of 513 bits
    big        = '0;
    big[W-1]   = 1'b1;
    ms0        = ms_cnt;
    do_txn(big, big, '1, 1, 1, lat, e, r);
    chk("ovf_lat",  W'(lat),          W'(3));
    chk("ovf_nreq", W'(ms_cnt - ms0), '0);
    chk("ovf_err",  W'(e),            W'(1));
    chk("ovf_res",  r,                W'(3));

    // silent engine
    eng_en = 1'b0;
    ms0    = ms_cnt;
    do_txn(W'(1), W'(2), W'(100), 1, 1, lat, e, r);
    eng_en = 1'b1;
    chk("tmo_lat",  W'(lat),          W'(4 + TO));
    chk("tmo_nreq", W'(ms_cnt - ms0), W'(1));
    chk("tmo_err",  W'(e),            W'(1));
    chk("tmo_res",  r,                W'(3));

    // response lands on the terminal-count cycle: 15 mod 10
    do_txn(W'(7), W'(8), W'(10), TO, 1, lat, e, r);
    chk("tie_lat", W'(lat), W'(4 + TO));
    chk("tie_err", W'(e),   '0);
    chk("tie_res", r,       W'(5));

    // start held for 10 cycles while busy: 7 mod 6
    ms0 = ms_cnt;
    dn0 = done_cnt;
    do_txn(W'(3), W'(4), W'(6), 8, 10, lat, e, r);
    chk("hold_lat",   W'(lat),            W'(12));
    chk("hold_res",   r,                  W'(1));
    chk("hold_nreq",  W'(ms_cnt - ms0),   W'(1));
    chk("hold_ndone", W'(done_cnt - dn0), W'(1));

    // zero operands; start also high during the done cycle
    ms0 = ms_cnt;
    do_txn(W'(0), W'(0), W'(7), 1, 5, lat, e, r);
    chk("zero_lat",   W'(lat),          W'(5));
    chk("zero_nreq",  W'(ms_cnt - ms0), W'(1));
    chk("zero_mod_a", ms_a,             '0);
    chk("zero_res",   r,                '0);
    chk("zero_err",   W'(e),            '0);
    chk("zero_idle",  W'(busy),         '0);

    // reset while waiting; the engine still answers afterwards
    eng_lat = 8;
    @(negedge clk);
    start = 1'b1;
    a     = W'(2);
    b     = W'(3);
    n     = W'(4);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", W'(busy), W'(1));
    resetn = 1'b0;
    #1;
    chk("arst_busy", W'(busy), '0);
    ms0 = ms_cnt;
    dn0 = done_cnt;
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rst2_ndone",  W'(done_cnt - dn0), '0);
    chk("rst2_nreq",   W'(ms_cnt - ms0),   '0);
    chk("rst2_busy",   W'(busy),           '0);
    chk("rst2_err",    W'(err),            '0);
    chk("rst2_res",    res,                '0);
    chk("rst2_mstart", W'(mod_start),      '0);
    chk("rst2_mod_a",  mod_a,              '0);
    chk("rst2_mod_n",  mod_n,              '0);

    // recovery: 22 mod 13
    do_txn(W'(10), W'(12), W'(13), 2, 1, lat, e, r);
    chk("rec_lat", W'(lat), W'(6));
    chk("rec_res", r,       W'(9));
    chk("rec_err", W'(e),   '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_add_initiator.md
MOD_ADD_INITIATOR -- requirements
Module: mod_add_initiator

Interface
REQ-001 SHALL have parameter WIDTH, default 513, operand/modulus width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 4096, maximum cycles spent waiting for mod_done.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request pulse; a, b, n sampled on same edge.
REQ-006 SHALL have port a  input  WIDTH  addend, required a < n.
REQ-007 SHALL have port b  input  WIDTH  addend, required b < n.
REQ-008 SHALL have port n  input  WIDTH  modulus.
REQ-009 SHALL have port busy  output  1  high from accepted start until done pulse.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err  output  1  valid with done: overflow or timeout.
REQ-012 SHALL have port res  output  WIDTH  (a+b) mod n, held until next done.
REQ-013 SHALL have port mod_start  output  1  one-cycle request to reduction engine.
REQ-014 SHALL have port mod_a  output  WIDTH  value to reduce, stable from mod_start until mod_done.
REQ-015 SHALL have port mod_n  output  WIDTH  modulus to engine, stable likewise.
REQ-016 SHALL have port mod_res  input  WIDTH  engine result, valid when mod_done high.
REQ-017 SHALL have port mod_done  input  1  engine completion pulse.

Function
REQ-018 SHALL implement FSM states IDLE, ADD, ISSUE, WAIT, FINISH.
REQ-019 IDLE: start=1 -> latch a, b, n into registers, go ADD; start ignored in every other state.
REQ-020 ADD: register sum = a_r + b_r at WIDTH+1 bits; carry bit set -> flag overflow, go FINISH without issuing; else go ISSUE.
REQ-021 ISSUE: mod_start=1 for exactly one cycle, mod_a = sum[WIDTH-1:0], mod_n = n_r; clear wait counter; go WAIT.
REQ-022 WAIT: mod_done=1 -> capture mod_res into res, go FINISH; counter increments each WAIT cycle.
REQ-023 WAIT: counter reaching TIMEOUT-1 without mod_done -> flag timeout, res unchanged, go FINISH.
REQ-024 FINISH: done=1 one cycle, err = overflow|timeout, return IDLE.
REQ-025 Latency without error: start edge to done = 4 cycles + engine latency (mod_start to mod_done).
REQ-026 mod_done arriving outside WAIT SHALL be ignored.
REQ-027 mod_done in same cycle as timeout terminal count: mod_done wins, err=0.
REQ-028 start in the FINISH cycle SHALL be ignored; earliest new accept is the cycle after done.
REQ-029 busy SHALL be combinational (state != IDLE).

Reset
REQ-030 resetn=0 SHALL asynchronously force state IDLE, done=0, err=0, mod_start=0, busy=0, res=0, counter=0, flags=0.
REQ-031 Reset mid-operation SHALL abandon the request; no done pulse follows; later mod_done ignored.
REQ-032 mod_a/mod_n registers SHALL reset to 0.

Structure
REQ-033 Shared package SHALL hold WIDTH default, TIMEOUT default, FSM state encoding (3 bits).
REQ-034 Counter width SHALL be $clog2(TIMEOUT).
REQ-035 Wide adder SHALL be one combinational add registered in ADD; no sub-module needed beyond optional wait_counter.
REQ-036 Block SHALL connect directly to the team's mod reduction engine (start/a/n/res/done).

Verification
REQ-037 a=5, b=9, n=11, engine model replies 14 mod 11 after 3 cycles -> mod_a=14, res=3, err=0, done at cycle 7.
REQ-038 a=0, b=0, n=7 -> mod_start once with mod_a=0, res=0, err=0.
REQ-039 a=b=2^512 (WIDTH 513) -> no mod_start, done after 3 cycles, err=1.
REQ-040 Engine never responds -> done exactly TIMEOUT cycles after mod_start+1, err=1, res unchanged.
REQ-041 start held high for 10 cycles -> exactly one transaction; second start accepted only after done.
REQ-042 resetn pulsed low during WAIT, then late mod_done -> no done, outputs all 0, FSM IDLE.
